// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin frame scheduler sharing one Ethernet TX header/payload interface between N_SRC byte FIFOs
module eth_tx_sched #(
  parameter int          N_SRC     = 4,
  parameter int          FRAME_LEN = 512,
  parameter logic [15:0] ETH_TYPE  = 16'h0800
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [47:0]          cfg_dest_mac,
  input  logic [47:0]          cfg_src_mac,
  input  logic [8*N_SRC-1:0]   s_axis_tdata,
  input  logic [N_SRC-1:0]     s_axis_tvalid,
  output logic [N_SRC-1:0]     s_axis_tready,
  input  logic [11*N_SRC-1:0]  s_fifo_count,
  output logic                 m_eth_hdr_valid,
  input  logic                 m_eth_hdr_ready,
  output logic [47:0]          m_eth_dest_mac,
  output logic [47:0]          m_eth_src_mac,
  output logic [15:0]          m_eth_type,
  output logic [7:0]           m_eth_payload_axis_tdata,
  output logic                 m_eth_payload_axis_tvalid,
  input  logic                 m_eth_payload_axis_tready,
  output logic                 m_eth_payload_axis_tlast,
  output logic                 m_eth_payload_axis_tuser,
  output logic                 busy,
  output logic [31:0]          frame_count
);
  localparam int GW = $clog2(N_SRC);
  typedef enum logic [2:0] {IDLE, HDR, TAG0, TAG1, PAYLOAD} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] grant, last_grant, pick;
  logic [N_SRC-1:0] req;
  logic [7:0] seq [N_SRC];
  logic [10:0] byte_cnt;
  logic found, launch, beat, done;
  // a source requests once it holds a full frame
  always_comb
    for (int i = 0; i < N_SRC; i++) req[i] = s_fifo_count[11*i +: 11] >= 11'(FRAME_LEN);
  // rotate search from last_grant+1; the nearest requester is assigned last and wins
  always_comb begin
    pick = last_grant;
    found = 1'b0;
    for (int k = N_SRC; k >= 1; k--)
      if (req[(int'(last_grant) + k) % N_SRC]) begin
        pick = GW'((int'(last_grant) + k) % N_SRC);
        found = 1'b1;
      end
  end
  assign launch = state == IDLE && enable && found;
  assign beat   = state == PAYLOAD && s_axis_tvalid[grant] && m_eth_payload_axis_tready;
  assign done   = beat && byte_cnt == 11'd1;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = launch ? HDR : IDLE;
      HDR:     state_nxt = m_eth_hdr_ready ? TAG0 : HDR;
      TAG0:    state_nxt = m_eth_payload_axis_tready ? TAG1 : TAG0;
      TAG1:    state_nxt = m_eth_payload_axis_tready ? PAYLOAD : TAG1;
      PAYLOAD: state_nxt = done ? IDLE : PAYLOAD;
      default: state_nxt = IDLE;
    endcase
  end
  // tag bytes come from registered state; payload is a zero-latency pass-through of the granted source
  always_comb begin
    m_eth_payload_axis_tvalid = state == TAG0 || state == TAG1 || (state == PAYLOAD && s_axis_tvalid[grant]);
    m_eth_payload_axis_tdata  = state == TAG0 ? 8'(grant) :
                                state == TAG1 ? seq[grant] :
                                state == PAYLOAD ? s_axis_tdata[{grant, 3'b000} +: 8] : 8'h00;
    m_eth_payload_axis_tlast  = state == PAYLOAD && byte_cnt == 11'd1;
    s_axis_tready = (state == PAYLOAD && m_eth_payload_axis_tready) ? {{(N_SRC-1){1'b0}}, 1'b1} << grant : '0;
  end
  assign m_eth_payload_axis_tuser = 1'b0;
  assign busy = state != IDLE;
  // grant, header fields, byte counter, per-source sequence and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      last_grant <= GW'(N_SRC - 1);
      m_eth_hdr_valid <= 1'b0;
      m_eth_dest_mac <= '0;
      m_eth_src_mac <= '0;
      m_eth_type <= '0;
      byte_cnt <= '0;
      frame_count <= '0;
      for (int i = 0; i < N_SRC; i++) seq[i] <= '0;
    end else begin
      if (launch) begin
        grant <= pick;
        last_grant <= pick;
        m_eth_dest_mac <= cfg_dest_mac;
        m_eth_src_mac <= cfg_src_mac;
        m_eth_type <= ETH_TYPE;
        m_eth_hdr_valid <= 1'b1;
      end
      if (state == HDR && m_eth_hdr_ready) m_eth_hdr_valid <= 1'b0;
      if (state == TAG1 && m_eth_payload_axis_tready) byte_cnt <= 11'(FRAME_LEN);
      if (beat) byte_cnt <= byte_cnt - 11'd1;
      if (done) begin
        seq[grant] <= seq[grant] + 8'd1;
        frame_count <= frame_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: randomized scoreboard bench for eth_tx_sched against a frame-level round-robin model
module tb_eth_tx_sched;
  localparam int N = 4;
  localparam int FL = 32;
  localparam logic [15:0] ET = 16'h0800;
  logic clk, rst, enable;
  logic [47:0] cfg_dest_mac, cfg_src_mac;
  logic [8*N-1:0] s_axis_tdata;
  logic [N-1:0] s_axis_tvalid, s_axis_tready;
  logic [11*N-1:0] s_fifo_count;
  logic m_eth_hdr_valid, m_eth_hdr_ready;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [7:0] m_eth_payload_axis_tdata;
  logic m_eth_payload_axis_tvalid, m_eth_payload_axis_tready, m_eth_payload_axis_tlast, m_eth_payload_axis_tuser;
  logic busy;
  logic [31:0] frame_count;
  eth_tx_sched #(.N_SRC(N), .FRAME_LEN(FL), .ETH_TYPE(ET)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_dest_mac(cfg_dest_mac), .cfg_src_mac(cfg_src_mac),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_fifo_count(s_fifo_count),
    .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_eth_payload_axis_tdata(m_eth_payload_axis_tdata), .m_eth_payload_axis_tvalid(m_eth_payload_axis_tvalid),
    .m_eth_payload_axis_tready(m_eth_payload_axis_tready), .m_eth_payload_axis_tlast(m_eth_payload_axis_tlast),
    .m_eth_payload_axis_tuser(m_eth_payload_axis_tuser),
    .busy(busy), .frame_count(frame_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {logic [7:0] d; logic l; int fr; int src;} beat_t;
  typedef struct {logic [47:0] dm; logic [47:0] sm;} hdr_t;
  beat_t exp_b[$];
  hdr_t exp_h[$];
  logic [7:0] src_q [N][$];
  logic [7:0] mdl_q [N][$];
  logic [7:0] m_seq [N];
  int m_last = N - 1;
  int m_frames = 0;
  int compared = 0, mismatched = 0;
  int hdr_seen = 0, pay_beats = 0, hdr_hold = 0;
  logic [N-1:0] hs_src = '0;
  function automatic void check(string n, logic [63:0] a, logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction
  function automatic void fail_now(string n);
    compared++;
    mismatched++;
    $display("FAIL %s", n);
  endfunction
  function automatic void load(int s, int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      src_q[s].push_back(b);
      mdl_q[s].push_back(b);
    end
  endfunction
  function automatic void reset_model();
    for (int i = 0; i < N; i++) begin
      m_seq[i] = 8'h00;
      src_q[i].delete();
      mdl_q[i].delete();
    end
    m_last = N - 1;
    m_frames = 0;
    hdr_seen = 0;
    exp_b.delete();
    exp_h.delete();
  endfunction
  function automatic void run_model(logic [47:0] dm, logic [47:0] sm);
    while (1) begin
      int g;
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && mdl_q[(m_last + k) % N].size() >= FL) g = (m_last + k) % N;
      if (g < 0) break;
      exp_h.push_back('{dm, sm});
      exp_b.push_back('{8'(g), 1'b0, m_frames, -1});
      exp_b.push_back('{m_seq[g], 1'b0, m_frames, -1});
      for (int b = 0; b < FL; b++) exp_b.push_back('{mdl_q[g].pop_front(), b == FL - 1, m_frames, g});
      m_seq[g] = m_seq[g] + 8'd1;
      m_last = g;
      m_frames++;
    end
  endfunction
  // sources, downstream ready and monitor: drive on negedge, judge handshakes 1 time unit later
  initial begin
    beat_t e;
    logic [N-1:0] exp_rdy;
    s_axis_tvalid = '0; s_axis_tdata = '0; s_fifo_count = '0;
    m_eth_hdr_ready = 1'b0; m_eth_payload_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (hs_src[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      m_eth_payload_axis_tready = 1'($urandom_range(0, 1));
      m_eth_hdr_ready = hdr_hold > 0 ? 1'b0 : 1'($urandom_range(0, 1));
      if (hdr_hold > 0) hdr_hold--;
      for (int i = 0; i < N; i++) begin
        s_axis_tvalid[i] = src_q[i].size() > 0 && $urandom_range(0, 7) != 0;
        s_axis_tdata[8*i +: 8] = src_q[i].size() > 0 ? src_q[i][0] : 8'h00;
        s_fifo_count[11*i +: 11] = src_q[i].size() > 2047 ? 11'd2047 : 11'(src_q[i].size());
      end
      #1;
      if (!rst) begin
        if (m_eth_payload_axis_tvalid) begin
          if (exp_b.size() == 0) fail_now("unexpected_payload_beat");
          else begin
            e = exp_b[0];
            check("payload_data", m_eth_payload_axis_tdata, e.d);
            check("payload_tlast", m_eth_payload_axis_tlast, e.l);
            check("payload_tuser", m_eth_payload_axis_tuser, 0);
            check("payload_after_header", e.fr < hdr_seen, 1);
            exp_rdy = (e.src >= 0 && m_eth_payload_axis_tready) ? {{(N-1){1'b0}}, 1'b1} << e.src : '0;
            check("src_tready", s_axis_tready, exp_rdy);
            if (m_eth_payload_axis_tready) begin
              void'(exp_b.pop_front());
              pay_beats++;
            end
          end
        end
        if (m_eth_hdr_valid) begin
          if (exp_h.size() == 0) fail_now("unexpected_header");
          else begin
            check("hdr_dest_mac", m_eth_dest_mac, exp_h[0].dm);
            check("hdr_src_mac", m_eth_src_mac, exp_h[0].sm);
            check("hdr_type", m_eth_type, ET);
            if (m_eth_hdr_ready) begin
              void'(exp_h.pop_front());
              hdr_seen++;
            end
          end
        end
      end
      hs_src = s_axis_tready & s_axis_tvalid;
    end
  end
  task automatic drain();
    int t;
    t = 0;
    while ((exp_b.size() > 0 || exp_h.size() > 0) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40000) fail_now("drain_timeout");
    repeat (4) @(negedge clk);
    #2;
    check("busy_after_drain", busy, 0);
    check("frame_count", frame_count, 64'(m_frames));
  endtask
  task automatic wait_beats(int n);
    int t, target;
    t = 0;
    target = pay_beats + n;
    while (pay_beats < target && t < 5000) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (t >= 5000) fail_now("beat_wait_timeout");
  endtask
  task automatic check_reset_outputs();
    check("rst_hdr_valid", m_eth_hdr_valid, 0);
    check("rst_dest_mac", m_eth_dest_mac, 0);
    check("rst_src_mac", m_eth_src_mac, 0);
    check("rst_type", m_eth_type, 0);
    check("rst_tvalid", m_eth_payload_axis_tvalid, 0);
    check("rst_tlast", m_eth_payload_axis_tlast, 0);
    check("rst_tuser", m_eth_payload_axis_tuser, 0);
    check("rst_src_tready", s_axis_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
  endtask
  // scenario sequence
  initial begin
    rst = 1'b1; enable = 1'b0;
    cfg_dest_mac = 48'({$urandom, $urandom}); cfg_src_mac = 48'({$urandom, $urandom});
    reset_model();
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    load(2, FL - 1);
    run_model(cfg_dest_mac, cfg_src_mac);
    repeat (30) @(negedge clk);
    #2;
    check("no_frame_below_len", frame_count, 0);
    @(negedge clk);
    hdr_hold = 12;
    load(2, 1);
    run_model(cfg_dest_mac, cfg_src_mac);
    drain();
    cfg_dest_mac = 48'({$urandom, $urandom}); cfg_src_mac = 48'({$urandom, $urandom});
    for (int i = 0; i < N; i++) load(i, 2 * FL);
    run_model(cfg_dest_mac, cfg_src_mac);
    drain();
    load(1, 257 * FL);
    run_model(cfg_dest_mac, cfg_src_mac);
    drain();
    load(0, FL);
    run_model(cfg_dest_mac, cfg_src_mac);
    wait_beats(12);
    @(negedge clk);
    enable = 1'b0;
    load(3, FL);
    drain();
    repeat (40) @(negedge clk);
    #2;
    check("no_frame_while_disabled", frame_count, 64'(m_frames));
    @(negedge clk);
    enable = 1'b1;
    run_model(cfg_dest_mac, cfg_src_mac);
    drain();
    load(2, FL);
    run_model(cfg_dest_mac, cfg_src_mac);
    wait_beats(17);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check_reset_outputs();
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) load(i, FL);
    run_model(cfg_dest_mac, cfg_src_mac);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
